// File: rtl/quad_dec_multi.sv
// quad_dec_multi
//   Multi-channel quadrature encoder decoder. Each channel synchronises its
//   raw A/B pins, debounces the pair jointly, decodes Gray-code transitions
//   into step pulses with direction, and keeps a clearable position counter
//   that either wraps or saturates.
// Parameters:
//   CH     number of independent channels
//   FILT   debounce length in cycles (>= 2)
//   CNT_W  position counter width per channel
//   MODE   0 = one step per detent (x1), 1 = one step per legal edge (x4)
//   SAT    0 = position wraps, 1 = position saturates at 0 / all-ones
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enc_a/enc_b raw encoder pins, one bit per channel
//   clr         per-channel synchronous clear of pos and err
//   step        one-cycle pulse per decoded step
//   dir         direction of last step (0 = CW/up, 1 = CCW/down)
//   pos         positions, channel i at [i*CNT_W +: CNT_W]
//   err         sticky illegal-transition flag
module quad_dec_multi #(
  parameter int CH    = 2,
  parameter int FILT  = 4,
  parameter int CNT_W = 8,
  parameter int MODE  = 0,
  parameter int SAT   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       enc_a,
  input  logic [CH-1:0]       enc_b,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       step,
  output logic [CH-1:0]       dir,
  output logic [CH*CNT_W-1:0] pos,
  output logic [CH-1:0]       err
);

  localparam int CW = (FILT > 2) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [1:0]       s1, s2, filt, cand, prev;
    logic [CW-1:0]    cnt;
    logic             valid, upd;
    logic             cw_t, ccw_t, ill_t, is_step, step_r, dir_r, err_r;
    logic [CNT_W-1:0] pos_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= '0;
        s2 <= '0;
      end else begin
        s1 <= {enc_b[i], enc_a[i]};
        s2 <= s1;
      end
    end

    // Before acquisition the window counts stability of any value, including
    // the reset value of filt, so the first stable window is always taken.
    // A filt change is handed to the decoder one cycle later through upd/prev.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt  <= '0;
        cand  <= '0;
        cnt   <= '0;
        valid <= 1'b0;
        upd   <= 1'b0;
        prev  <= '0;
      end else begin
        upd <= 1'b0;
        if (!valid) begin
          if (s2 == cand) begin
            if (cnt == CMAX) begin
              filt  <= s2;
              valid <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cand <= s2;
            cnt  <= CW'(1);
          end
        end else if (s2 == cand && cnt == CMAX) begin
          filt <= s2;
          prev <= filt;
          upd  <= 1'b1;
          cnt  <= '0;
        end else if (s2 == filt) begin
          cand <= s2;
          cnt  <= '0;
        end else if (s2 != cand) begin
          cand <= s2;
          cnt  <= CW'(1);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    always_comb begin
      cw_t  = (prev == 2'b00 && filt == 2'b01) || (prev == 2'b01 && filt == 2'b11) ||
              (prev == 2'b11 && filt == 2'b10) || (prev == 2'b10 && filt == 2'b00);
      ccw_t = (prev == 2'b00 && filt == 2'b10) || (prev == 2'b10 && filt == 2'b11) ||
              (prev == 2'b11 && filt == 2'b01) || (prev == 2'b01 && filt == 2'b00);
      ill_t = (prev ^ filt) == 2'b11;
      if (MODE == 1) begin
        is_step = cw_t || ccw_t;
      end else begin
        is_step = filt == 2'b11 && (prev == 2'b01 || prev == 2'b10);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        step_r <= 1'b0;
        dir_r  <= 1'b0;
        err_r  <= 1'b0;
        pos_r  <= '0;
      end else begin
        step_r <= upd && is_step;
        if (upd && is_step) begin
          dir_r <= ccw_t;
        end
        if (clr[i]) begin
          pos_r <= '0;
        end else if (upd && is_step) begin
          if (ccw_t) begin
            if (!(SAT != 0 && pos_r == '0)) pos_r <= pos_r - 1'b1;
          end else begin
            if (!(SAT != 0 && pos_r == '1)) pos_r <= pos_r + 1'b1;
          end
        end
        if (clr[i]) begin
          err_r <= 1'b0;
        end else if (upd && ill_t) begin
          err_r <= 1'b1;
        end
      end
    end

    assign step[i]                  = step_r;
    assign dir[i]                   = dir_r;
    assign err[i]                   = err_r;
    assign pos[i*CNT_W +: CNT_W]    = pos_r;
  end

endmodule
